// File: rtl/traffic_sensor_cond.sv
// traffic_sensor_cond: conditions two raw vehicle sensors for the traffic-light
// controller. Each raw input is synchronised with a two-flop chain and then
// debounced. The two debounced levels are arbitrated into TAORB
// (1 = serve road A, 0 = serve road B). TAORB is allowed to change only after
// a minimum dwell has elapsed since its previous change.
//
// Optional feature: define TRAFFIC_SENSOR_FAIRNESS_EN to make TAORB alternate
// while both roads are busy. When the macro is undefined, both roads busy
// holds TAORB where it is.

`timescale 1ns/1ps

module traffic_sensor_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 2000000,  // must be >= 2
  parameter int unsigned HOLD_CYCLES     = 100000000 // must be >= 1
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic sensor_a_raw,
  input  logic sensor_b_raw,
  output logic TAORB,
  output logic sensor_a_db,
  output logic sensor_b_db,
  output logic taorb_changed
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

  // The counter value at which the next mismatching cycle completes the run.
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

  // Bit 0 carries road A and bit 1 carries road B throughout.
  logic [1:0]      raw;
  logic [1:0]      sync_1;
  logic [1:0]      sync_2;
  logic [1:0]      db;
  logic [DB_W-1:0] db_cnt [2];

  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_done;
  logic              want;

  assign raw         = {sensor_b_raw, sensor_a_raw};
  assign sensor_a_db = db[0];
  assign sensor_b_db = db[1];
  assign hold_done   = (hold_cnt == HOLD_MAX);

  // Two-flop synchroniser per channel. The raw inputs are asynchronous to clk_100MHz.
  // NOTE: every clocked block uses non-blocking assignments. Each stage then reads
  // the value it held before this edge, which is what makes the chain two deep.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
    end
  end

  // Per-channel debounce. A new level is accepted only after it has been
  // seen for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      db <= '0;
      // NOTE: db_cnt is an array of a few flops, not a RAM. It must start cleared,
      // otherwise a partial count could be left over, so it takes the reset like
      // any other state.
      for (int ch = 0; ch < 2; ch++) begin
        db_cnt[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (sync_2[ch] == db[ch]) begin
          db_cnt[ch] <= '0;
        end else if (db_cnt[ch] == DB_LAST) begin
          db[ch]     <= sync_2[ch];
          db_cnt[ch] <= '0;
        end else begin
          db_cnt[ch] <= db_cnt[ch] + DB_W'(1);
        end
      end
    end
  end

  // Request decode. A single busy road claims service. Otherwise TAORB holds,
  // except when both roads are busy and the fairness feature is built in.
  always_comb begin
    // NOTE: want gets its default before the case. This way no path leaves it
    // unassigned, so no latch is inferred.
    want = TAORB;
    case (db)
      2'b01:   want = 1'b1;
      2'b10:   want = 1'b0;
`ifdef TRAFFIC_SENSOR_FAIRNESS_EN
      2'b11:   want = hold_done ? ~TAORB : TAORB;
`endif
      default: want = TAORB;
    endcase
  end

  // TAORB update, gated by the minimum-dwell counter. The counter restarts on
  // every change and saturates once the dwell is met. A pending request is
  // therefore re-evaluated every cycle and applies as soon as it is allowed.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      TAORB         <= 1'b1;
      taorb_changed <= 1'b0;
      hold_cnt      <= HOLD_MAX;
    end else begin
      taorb_changed <= 1'b0;
      if ((want != TAORB) && hold_done) begin
        TAORB         <= want;
        taorb_changed <= 1'b1;
        hold_cnt      <= '0;
      end else if (!hold_done) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_traffic_sensor_cond.sv
// tb_traffic_sensor_cond: directed and randomized stimulus for traffic_sensor_cond.
// A reference model checks every cycle. The model keeps the raw sample history of
// each channel and the edge index of the last TAORB change. It accepts a debounced
// level once the relevant window of samples is uniformly opposite, and it permits
// a change once more than HOLD edges have passed since the last one.

`timescale 1ns/1ps

module tb_traffic_sensor_cond;

  localparam int DB   = 4;
  localparam int HOLD = 8;
  localparam int HIST = DB + 2;

`ifdef TRAFFIC_SENSOR_FAIRNESS_EN
  localparam int T5_PULSES = 4;
`else
  localparam int T5_PULSES = 0;
`endif

  logic clk_100MHz = 1'b0;
  logic reset;
  logic sensor_a_raw;
  logic sensor_b_raw;
  logic TAORB;
  logic sensor_a_db;
  logic sensor_b_db;
  logic taorb_changed;

  int checks   = 0;
  int failures = 0;

  traffic_sensor_cond #(
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (HOLD)
  ) dut (
    .clk_100MHz   (clk_100MHz),
    .reset        (reset),
    .sensor_a_raw (sensor_a_raw),
    .sensor_b_raw (sensor_b_raw),
    .TAORB        (TAORB),
    .sensor_a_db  (sensor_a_db),
    .sensor_b_db  (sensor_b_db),
    .taorb_changed(taorb_changed)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  // Reference model state.
  // hist_x holds raw samples, oldest first; the newest sample is at index HIST-1.
  bit hist_a[$];
  bit hist_b[$];
  bit m_db_a, m_db_b, m_taorb, m_changed, m_ever;
  int m_cyc, m_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist_a.delete();
    hist_b.delete();
    for (int i = 0; i < HIST; i++) begin
      hist_a.push_back(1'b0);
      hist_b.push_back(1'b0);
    end
    m_db_a    = 1'b0;
    m_db_b    = 1'b0;
    m_taorb   = 1'b1;
    m_changed = 1'b0;
    m_ever    = 1'b0;
    m_cyc     = 0;
    m_last    = 0;
  endtask

  // The level flips when the DB samples taken 2..DB+1 edges ago all disagree with it.
  function automatic bit flips(input bit h[$], input bit cur);
    for (int i = 0; i < DB; i++) begin
      if (h[i] == cur) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_edge(input bit ra, input bit rb);
    bit want;
    bit permitted;
    m_cyc++;
    permitted = !m_ever || ((m_cyc - m_last) > HOLD);
    want = m_taorb;
    if (m_db_a && !m_db_b)      want = 1'b1;
    else if (!m_db_a && m_db_b) want = 1'b0;
`ifdef TRAFFIC_SENSOR_FAIRNESS_EN
    else if (m_db_a && m_db_b && permitted) want = !m_taorb;
`endif
    m_changed = (want != m_taorb) && permitted;
    if (m_changed) begin
      m_taorb = want;
      m_last  = m_cyc;
      m_ever  = 1'b1;
    end
    hist_a.push_back(ra);
    void'(hist_a.pop_front());
    hist_b.push_back(rb);
    void'(hist_b.pop_front());
    if (flips(hist_a, m_db_a)) m_db_a = !m_db_a;
    if (flips(hist_b, m_db_b)) m_db_b = !m_db_b;
  endtask

  // Drive the raw inputs at the falling edge, then take one rising edge.
  // Check all outputs 1 ns later.
  task automatic step(input bit ra, input bit rb);
    @(negedge clk_100MHz);
    sensor_a_raw = ra;
    sensor_b_raw = rb;
    @(posedge clk_100MHz);
    model_edge(ra, rb);
    #1;
    check("taorb",   TAORB,         m_taorb);
    check("db_a",    sensor_a_db,   m_db_a);
    check("db_b",    sensor_b_db,   m_db_b);
    check("changed", taorb_changed, m_changed);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    bit ra;
    bit rb;
    int len;

    reset        = 1'b1;
    sensor_a_raw = 1'b0;
    sensor_b_raw = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_100MHz);
    #1;
    check("rst_taorb",   TAORB,         1'b1);
    check("rst_db_a",    sensor_a_db,   1'b0);
    check("rst_db_b",    sensor_b_db,   1'b0);
    check("rst_changed", taorb_changed, 1'b0);
    @(posedge clk_100MHz);
    #2 reset = 1'b0;
    model_reset();

    // 1: idle inputs leave everything at reset values.
    pulses = 0;
    for (int i = 1; i <= 50; i++) begin
      step(1'b0, 1'b0);
      pulses += int'(taorb_changed);
    end
    check("t1_pulses", pulses, 0);
    check("t1_taorb", TAORB, 1'b1);

    // 2: a clean B edge sampled at edge 11 gives db at edge 16 and the change at edge 17.
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, i >= 11);
      if (i == 15) check("t2_db_b_early", sensor_b_db, 1'b0);
      if (i == 16) check("t2_db_b_rise", sensor_b_db, 1'b1);
      if (i == 16) check("t2_taorb_held", TAORB, 1'b1);
      if (i == 17) check("t2_taorb_to_b", TAORB, 1'b0);
      if (i == 17) check("t2_pulse", taorb_changed, 1'b1);
      if (i == 18) check("t2_pulse_end", taorb_changed, 1'b0);
    end

    // 3: A bounces every two clocks, which never reaches the debounced output.
    for (int i = 0; i < 50; i++) begin
      step((i < 40) ? bit'((i / 2) % 2) : 1'b0, 1'b1);
      check("t3_db_a_low", sensor_a_db, 1'b0);
    end
    check("t3_taorb", TAORB, 1'b0);

    // 4: the request that arrives 3 cycles after a change waits out the hold.
    for (int i = 0; i < 30; i++) begin
      ra = (i < 12) || (i >= 16);
      step(ra, !ra);
      if (i == 6)  check("t4_to_a", TAORB, 1'b1);
      if (i == 18) check("t4_to_b", TAORB, 1'b0);
      if (i == 18) check("t4_pulse_b", taorb_changed, 1'b1);
      if (i == 21) check("t4_db_a_back", sensor_a_db, 1'b1);
      if (i == 26) check("t4_still_b", TAORB, 1'b0);
      if (i == 27) check("t4_back_to_a", TAORB, 1'b1);
      if (i == 27) check("t4_pulse_a", taorb_changed, 1'b1);
    end

    // 5: both roads busy.
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1);
      pulses += int'(taorb_changed);
    end
    check("t5_pulses", pulses, T5_PULSES);

    // Randomized bursts, including glitches shorter than the debounce window.
    for (int n = 0; n < 60; n++) begin
      ra  = 1'($urandom_range(0, 1));
      rb  = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 9));
      for (int k = 0; k < len; k++) step(ra, rb);
    end

    // 6: asynchronous reset mid-hold and mid-debounce, then a clean B edge.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(i >= 7, i < 7);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_taorb",   TAORB,         1'b1);
    check("t6_rst_db_a",    sensor_a_db,   1'b0);
    check("t6_rst_db_b",    sensor_b_db,   1'b0);
    check("t6_rst_changed", taorb_changed, 1'b0);
    repeat (2) @(posedge clk_100MHz);
    #2 reset = 1'b0;
    model_reset();
    for (int i = 0; i <= 10; i++) begin
      step(1'b0, i >= 1);
      if (i == 5) check("t6_db_b_early", sensor_b_db, 1'b0);
      if (i == 6) check("t6_db_b_rise", sensor_b_db, 1'b1);
      if (i == 7) check("t6_taorb_to_b", TAORB, 1'b0);
      if (i == 7) check("t6_pulse", taorb_changed, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
